cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Miss-handling controller shared by the I-cache and D-cache; owns the single memory port.
- On a miss it issues 8 pipelined word reads and streams the returned words into the missing cache (FSM address, FSM data, data write-enable), then pulses that cache's metadata write-enable.
- Also forwards D-cache write-through stores to memory.
- Sits between both caches and the 4-cycle pipelined main memory.

Parameters:
- MEM_LAT, 4, cycles from read issue (mem_en=1, mem_wr=0) to the matching mem_valid.
- WORDS, 8, 16-bit words per cache block (offset = addr[3:1]).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- icache_miss  in  1  I-cache Miss
- icache_addr  in  16  I-cache CPU address; held stable while i_stall=1
- dcache_miss  in  1  D-cache Miss
- dcache_addr  in  16  D-cache CPU address; held stable while d_stall=1
- dcache_wr  in  1  D-cache store request (write-through)
- dcache_wdata  in  16  store data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid
- mem_en  out  1  memory request
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- fsm_addr  out  16  address into both caches' Addr_FSM
- fsm_data  out  16  data into both caches' DataIn_FSM
- i_data_we  out  1  I-cache Data_WE
- i_meta_we  out  1  I-cache MetaData_WE
- d_data_we  out  1  D-cache Data_WE
- d_meta_we  out  1  D-cache MetaData_WE
- i_stall  out  1  freeze fetch
- d_stall  out  1  freeze memory stage

Behaviour:
- States: IDLE, WRITE, FILL, META.
- Reset (async, rst_n=0):
  - state=IDLE; issue_cnt=0, recv_cnt=0; owner=D; blk_addr=0.
  - All mem_* and *_we outputs 0; fsm_addr=0, fsm_data=0.
  - Stalls are combinational from the inputs. Reset takes effect mid-fill, with no completion of the fill.
- IDLE arbitration, fixed priority dcache_wr > dcache_miss > icache_miss:
  - dcache_wr -> WRITE.
  - Otherwise a miss latches blk_addr={addr[15:4],4'b0} and owner, then -> FILL.
- WRITE: one cycle.
  - mem_en=1, mem_wr=1, mem_addr=dcache_addr, mem_wdata=dcache_wdata.
  - Then -> IDLE. The write is posted; no response.
- FILL, issue side:
  - While issue_cnt<WORDS: mem_en=1, mem_wr=0, mem_addr={blk_addr[15:4],issue_cnt,1'b0}.
  - issue_cnt increments each cycle and saturates at WORDS, then mem_en=0.
- FILL, receive side:
  - On each cycle with mem_valid=1: fsm_addr={blk_addr[15:4],recv_cnt,1'b0}, fsm_data=mem_rdata.
  - The owner's data_we=1 in that same cycle (combinational); recv_cnt increments.
  - After the 8th word -> META.
- META: one cycle.
  - The owner's meta_we=1, fsm_addr=blk_addr; then -> IDLE, with counters cleared.
- Latency: FILL entered at cycle 0 gives data_we at cycles MEM_LAT..MEM_LAT+7, meta_we at cycle MEM_LAT+8, IDLE at MEM_LAT+9.
- Stalls:
  - d_stall = dcache_miss | dcache_wr | (state!=IDLE & owner==D).
  - i_stall = icache_miss | (state!=IDLE & owner==I).
  - A second requester waits in stall until the controller returns to IDLE: one bubble cycle, then it is granted.
- Boundary cases:
  - mem_valid in IDLE, WRITE or META is ignored.
  - A miss deasserting mid-fill does not abort; the block completes.
  - Simultaneous I and D miss: D is served first; I follows on the first IDLE cycle after D's META.
  - The data-array address comes only from fsm_addr; blk_addr stays constant for the whole fill.
  - WRITE and FILL never overlap, so mem_en is never driven for two purposes.

Decomposition:
- Shared package cache_pkg holds:
  - state enum (IDLE/WRITE/FILL/META);
  - owner encoding (I=0, D=1);
  - WORDS_PER_BLK=8, OFFSET_W=3, ADDR_W=16.
- One natural sub-module: cache_word_cnt, a 3-bit+done counter with clear, enable and saturate. It is instantiated twice, for issue and receive.

Test Plan:
- D-miss at dcache_addr=16'h1236 (memory model returns 16'hA000+word): mem reads 16'h1230..16'h123E on cycles 0-7; d_data_we at cycles 4-11 with fsm_addr=16'h1230..16'h123E, fsm_data=A000..A007; d_meta_we at cycle 12 with fsm_addr=16'h1230; d_stall drops after.
- icache_miss and dcache_miss rise together (i addr 16'h0040, d addr 16'h2000): D fill completes first (meta at cycle 12); I fill issues 16'h0040 starting cycle 14; i_stall is held high throughout.
- dcache_wr with wdata=16'hBEEF, addr=16'h3004 in IDLE, with a concurrent I-miss: one cycle of mem_en=1, mem_wr=1, mem_addr=16'h3004, mem_wdata=16'hBEEF; the I fill starts 2 cycles later.
- rst_n pulsed low at cycle 6 of a D fill: all outputs go 0 immediately (asynchronously); after release, late mem_valid pulses produce no data_we.
- Spurious mem_valid=1 in IDLE: no *_we asserts and counters stay 0.
- dcache_miss deasserted at cycle 3 of a fill: all 8 d_data_we plus d_meta_we still occur.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache miss/fill controller.
// Blocks are 8 x 16-bit words; the word offset is addr[3:1].
package cache_pkg;
    localparam int ADDR_W        = 16;
    localparam int WORDS_PER_BLK = 8;
    localparam int OFFSET_W      = 3;
    localparam logic [ADDR_W-1:0] BLK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        META  = 2'd3
    } fill_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;
endpackage

// File: rtl/cache_word_cnt.sv
// Word counter for one block: counts 0..WORDS_PER_BLK and holds there.
// done is the saturated state; cnt is the word offset while counting.
module cache_word_cnt
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    output logic [OFFSET_W-1:0] cnt,
    output logic                done
);
    logic [OFFSET_W:0] val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            val <= '0;
        else if (clr)
            val <= '0;
        else if (en && !val[OFFSET_W])
            val <= val + 1'b1;
    end

    assign cnt  = val[OFFSET_W-1:0];
    assign done = val[OFFSET_W];
endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss/fill controller shared by I- and D-cache: owns the memory port,
// streams 8-word block fills into the missing cache and posts D-cache stores.
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr,
    input  logic [15:0]       dcache_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W-1:0] fsm_addr,
    output logic [15:0]       fsm_data,
    output logic              i_data_we,
    output logic              i_meta_we,
    output logic              d_data_we,
    output logic              d_meta_we,
    output logic              i_stall,
    output logic              d_stall
);
    fill_state_t       state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [ADDR_W-1:0] blk_addr, blk_addr_nxt;
    logic [OFFSET_W-1:0] issue_cnt, recv_cnt;
    logic              issue_done, recv_done;
    logic              issue_en, recv_en, cnt_clr;

    cache_word_cnt u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (issue_en),
        .cnt   (issue_cnt),
        .done  (issue_done)
    );

    cache_word_cnt u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (recv_en),
        .cnt   (recv_cnt),
        .done  (recv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWNER_D;
            blk_addr <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            blk_addr <= blk_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        blk_addr_nxt = blk_addr;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fsm_addr     = '0;
        fsm_data     = '0;
        i_data_we    = 1'b0;
        i_meta_we    = 1'b0;
        d_data_we    = 1'b0;
        d_meta_we    = 1'b0;
        issue_en     = 1'b0;
        recv_en      = 1'b0;
        cnt_clr      = 1'b0;
        case (state)
            IDLE: begin
                // Store first, then D-miss, then I-miss.
                if (dcache_wr) begin
                    state_nxt = WRITE;
                end else if (dcache_miss) begin
                    owner_nxt    = OWNER_D;
                    blk_addr_nxt = dcache_addr & BLK_MASK;
                    state_nxt    = FILL;
                end else if (icache_miss) begin
                    owner_nxt    = OWNER_I;
                    blk_addr_nxt = icache_addr & BLK_MASK;
                    state_nxt    = FILL;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = dcache_addr;
                mem_wdata = dcache_wdata;
                state_nxt = IDLE;
            end
            FILL: begin
                if (!issue_done) begin
                    mem_en   = 1'b1;
                    mem_addr = {blk_addr[ADDR_W-1:OFFSET_W+1], issue_cnt, 1'b0};
                    issue_en = 1'b1;
                end
                // Returned words are written straight through, in issue order.
                if (mem_valid && !recv_done) begin
                    recv_en  = 1'b1;
                    fsm_addr = {blk_addr[ADDR_W-1:OFFSET_W+1], recv_cnt, 1'b0};
                    fsm_data = mem_rdata;
                    if (owner == OWNER_D) d_data_we = 1'b1;
                    else                  i_data_we = 1'b1;
                    if (recv_cnt == OFFSET_W'(WORDS_PER_BLK - 1))
                        state_nxt = META;
                end
            end
            META: begin
                fsm_addr = blk_addr;
                if (owner == OWNER_D) d_meta_we = 1'b1;
                else                  i_meta_we = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign d_stall = dcache_miss | dcache_wr | ((state != IDLE) && (owner == OWNER_D));
    assign i_stall = icache_miss | ((state != IDLE) && (owner == OWNER_I));
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: 4-cycle pipelined memory model plus a
// schedule-based reference that predicts every output each cycle.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_miss, dcache_miss, dcache_wr;
    logic [15:0] icache_addr, dcache_addr, dcache_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fsm_addr, fsm_data;
    logic        i_data_we, i_meta_we, d_data_we, d_meta_we, i_stall, d_stall;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .dcache_wr(dcache_wr), .dcache_wdata(dcache_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fsm_addr(fsm_addr), .fsm_data(fsm_data),
        .i_data_we(i_data_we), .i_meta_we(i_meta_we),
        .d_data_we(d_data_we), .d_meta_we(d_meta_we),
        .i_stall(i_stall), .d_stall(d_stall)
    );

    // Memory: a read issued in cycle c returns in cycle c+4; never reset.
    logic [15:0] mem_seed = 16'hA000;
    logic        spur = 1'b0;
    logic [3:0]  pv = 4'b0;
    logic [15:0] pa [4];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem_seed + {13'b0, a[3:1]};
    endfunction

    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en && !mem_wr};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign mem_valid = pv[3] | spur;
    assign mem_rdata = spur ? 16'hDEAD : mem_word(pa[3]);

    int n_tests = 0, n_fail = 0;
    int t = 0, free_at = 0, js = 0;
    int drop_d = -1, drop_i = -1, drop_w = -1;
    bit jwr = 1'b0, jown = 1'b1, last_own = 1'b1;
    logic [15:0] jblk = '0, jaddr = '0, jwdata = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_en"}, 16'(mem_en), 16'h0);
        chk({tag, ".mem_wr"}, 16'(mem_wr), 16'h0);
        chk({tag, ".mem_addr"}, mem_addr, 16'h0);
        chk({tag, ".mem_wdata"}, mem_wdata, 16'h0);
        chk({tag, ".fsm_addr"}, fsm_addr, 16'h0);
        chk({tag, ".fsm_data"}, fsm_data, 16'h0);
        chk({tag, ".we"}, 16'({i_data_we, i_meta_we, d_data_we, d_meta_we}), 16'h0);
        chk({tag, ".stall"}, 16'({i_stall, d_stall}), 16'h0);
    endtask

    // Predict cycle t from the current job's start time, compare at negedge,
    // then advance to the start of the next cycle and retire served requests.
    task automatic step();
        logic e_men, e_mwr, e_idwe, e_imwe, e_ddwe, e_dmwe, e_is, e_ds;
        logic [15:0] e_ma, e_mwd, e_fa, e_fd;
        int k;
        bit own;
        {e_men, e_mwr, e_idwe, e_imwe, e_ddwe, e_dmwe} = '0;
        e_ma = '0; e_mwd = '0; e_fa = '0; e_fd = '0;
        own = last_own;
        if (t < free_at) begin
            k = t - js;
            if (jwr) begin
                e_men = 1'b1; e_mwr = 1'b1; e_ma = jaddr; e_mwd = jwdata;
            end else begin
                own = jown;
                if (k < 8) begin
                    e_men = 1'b1; e_ma = jblk + 16'(2 * k);
                end
                if (k >= 4 && k < 12) begin
                    e_fa = jblk + 16'(2 * (k - 4));
                    e_fd = mem_word(e_fa);
                    if (own) e_ddwe = 1'b1; else e_idwe = 1'b1;
                end
                if (k == 12) begin
                    e_fa = jblk;
                    if (own) e_dmwe = 1'b1; else e_imwe = 1'b1;
                end
            end
            e_ds = dcache_miss | dcache_wr | own;
            e_is = icache_miss | !own;
        end else begin
            e_ds = dcache_miss | dcache_wr;
            e_is = icache_miss;
            if (dcache_wr) begin
                jwr = 1'b1; jaddr = dcache_addr; jwdata = dcache_wdata;
                js = t + 1; free_at = t + 2; drop_w = t + 1;
            end else if (dcache_miss) begin
                jwr = 1'b0; jown = 1'b1; jblk = dcache_addr & 16'hFFF0; last_own = 1'b1;
                js = t + 1; free_at = t + 14; drop_d = t + 14;
            end else if (icache_miss) begin
                jwr = 1'b0; jown = 1'b0; jblk = icache_addr & 16'hFFF0; last_own = 1'b0;
                js = t + 1; free_at = t + 14; drop_i = t + 14;
            end
        end
        @(negedge clk);
        chk("mem_en", 16'(mem_en), 16'(e_men));
        chk("mem_wr", 16'(mem_wr), 16'(e_mwr));
        chk("mem_addr", mem_addr, e_ma);
        chk("mem_wdata", mem_wdata, e_mwd);
        chk("fsm_addr", fsm_addr, e_fa);
        chk("fsm_data", fsm_data, e_fd);
        chk("i_data_we", 16'(i_data_we), 16'(e_idwe));
        chk("i_meta_we", 16'(i_meta_we), 16'(e_imwe));
        chk("d_data_we", 16'(d_data_we), 16'(e_ddwe));
        chk("d_meta_we", 16'(d_meta_we), 16'(e_dmwe));
        chk("i_stall", 16'(i_stall), 16'(e_is));
        chk("d_stall", 16'(d_stall), 16'(e_ds));
        @(posedge clk);
        #1;
        t++;
        if (t == drop_d) dcache_miss = 1'b0;
        if (t == drop_i) icache_miss = 1'b0;
        if (t == drop_w) dcache_wr = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((t < free_at || dcache_miss || icache_miss || dcache_wr) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_tests++; n_fail++;
            $error("FAIL timeout t=%0d observed=busy expected=idle", t);
        end
        repeat (2) step();
    endtask

    initial begin
        rst_n = 1'b0;
        {icache_miss, dcache_miss, dcache_wr} = '0;
        icache_addr = '0; dcache_addr = '0; dcache_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single D-miss, memory returns A000+word.
        mem_seed = 16'hA000;
        dcache_addr = 16'h1236; dcache_miss = 1'b1;
        wait_done();

        // Simultaneous I and D misses: D served first.
        mem_seed = 16'h5100;
        icache_addr = 16'h0040; dcache_addr = 16'h2000;
        icache_miss = 1'b1; dcache_miss = 1'b1;
        wait_done();

        // Posted store with a concurrent I-miss.
        mem_seed = 16'h7700;
        dcache_addr = 16'h3004; dcache_wdata = 16'hBEEF; dcache_wr = 1'b1;
        icache_addr = 16'h4452; icache_miss = 1'b1;
        wait_done();

        // Spurious mem_valid while idle must be ignored.
        spur = 1'b1;
        repeat (3) step();
        spur = 1'b0;
        step();

        // Miss drops at fill cycle 3; the block still completes.
        mem_seed = 16'h0C30;
        dcache_addr = 16'h8A1E; dcache_miss = 1'b1;
        step();
        repeat (3) step();
        dcache_miss = 1'b0;
        wait_done();

        // Asynchronous reset at fill cycle 6; late returns must be ignored.
        dcache_addr = 16'hC0DE; dcache_miss = 1'b1;
        step();
        repeat (6) step();
        #1;
        rst_n = 1'b0;
        dcache_miss = 1'b0;
        #1;
        chk_all_zero("rst_async");
        #1;
        rst_n = 1'b1;
        free_at = t; last_own = 1'b1;
        drop_d = -1; drop_i = -1; drop_w = -1;
        repeat (10) step();

        // Randomized request mixes.
        repeat (12) begin
            int r;
            r = int'($urandom_range(1, 7));
            mem_seed = 16'($urandom);
            dcache_addr = 16'($urandom); icache_addr = 16'($urandom);
            dcache_wdata = 16'($urandom);
            dcache_wr = r[0]; dcache_miss = r[1]; icache_miss = r[2];
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
